// File: rtl/spi_target_pkg.sv
// Shared constants and types for the spi_target SPI mode-0 register target.
// Holds the register map, command byte field positions and FSM state encoding.
package spi_target_pkg;

    localparam logic [2:0] ADDR_ID       = 3'h0;
    localparam logic [2:0] ADDR_CTRL     = 3'h1;
    localparam logic [2:0] ADDR_INT_EN   = 3'h2;
    localparam logic [2:0] ADDR_INT_STAT = 3'h3;
    localparam logic [2:0] ADDR_SCRATCH0 = 3'h4;
    localparam logic [2:0] ADDR_SCRATCH1 = 3'h5;
    localparam logic [2:0] ADDR_SCRATCH2 = 3'h6;
    localparam logic [2:0] ADDR_SCRATCH3 = 3'h7;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_target_if.sv
// SPI pin bundle between the master (top) and the spi_target device.
// The master drives SS/SCLK/MOSI; the target drives MISO and INT.
interface spi_target_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS, output SCLK, output MOSI, input MISO, input INT);
    modport slave  (input SS, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/spi_target_sync.sv
// Multi-stage synchronizer for an asynchronous pin, with one extra flop
// providing single-cycle rise/fall pulses in the clk domain.
module spi_target_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{INIT}};
            prev_r  <= INIT;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign q    = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, command/data FSM, 8-entry register file
// and a level interrupt built from edge-latched local sources.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_52,
    input  logic        RESET_N,
    spi_target_if.slave spi,
    input  logic [3:0]  irq_src,
    output logic [7:0]  ctrl
);
    logic       ss_lvl_s, ss_rise_s, ss_fall_s;
    logic       sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic       mosi_lvl_s, mosi_rise_s, mosi_fall_s;
    logic [3:0] irq_lvl_s, irq_rise_s, irq_fall_s;
    logic       sync_unused_s;

    state_t     state_r, state_nxt_s;
    logic [2:0] bit_cnt_r;
    logic [2:0] addr_r;
    logic       byte_done_r;
    logic       rd_r;
    logic [7:0] rx_r;
    logic [7:0] rx_byte_s;
    logic [7:0] tx_r;
    logic [7:0] rd_data_s;
    logic       miso_r;
    logic       int_r;
    logic [7:0] ctrl_r;
    logic [3:0] int_en_r, int_en_nxt_s;
    logic [3:0] int_stat_r, int_stat_nxt_s;
    logic [7:0] scratch_r [4];
    logic       active_s;
    logic       last_bit_s;
    logic       wr_en_s;

    spi_target_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ss (
        .clk(clk_52), .rst_n(RESET_N), .d(spi.SS),
        .q(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk_52), .rst_n(RESET_N), .d(spi.SCLK),
        .q(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clk(clk_52), .rst_n(RESET_N), .d(spi.MOSI),
        .q(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    for (genvar g = 0; g < 4; g++) begin : g_irq_sync
        spi_target_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_irq (
            .clk(clk_52), .rst_n(RESET_N), .d(irq_src[g]),
            .q(irq_lvl_s[g]), .rise(irq_rise_s[g]), .fall(irq_fall_s[g])
        );
    end

    assign sync_unused_s = ^{ss_rise_s, ss_fall_s, sclk_lvl_s, mosi_rise_s,
                             mosi_fall_s, irq_lvl_s, irq_fall_s};

    // SS high aborts whatever is in flight, including a partial byte.
    assign active_s   = (state_r != IDLE) && !ss_lvl_s;
    assign last_bit_s = sclk_rise_s && (bit_cnt_r == 3'd7);
    assign rx_byte_s  = {rx_r[6:0], mosi_lvl_s};
    assign wr_en_s    = active_s && (state_r == DATA) && !rd_r && last_bit_s;

    // FSM state register.
    always_ff @(posedge clk_52 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: command byte first, then data bytes until SS rises.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!ss_lvl_s) state_nxt_s = CMD;
                else           state_nxt_s = IDLE;
            end
            CMD: begin
                if (ss_lvl_s)        state_nxt_s = IDLE;
                else if (last_bit_s) state_nxt_s = DATA;
                else                 state_nxt_s = CMD;
            end
            DATA: begin
                if (ss_lvl_s) state_nxt_s = IDLE;
                else          state_nxt_s = DATA;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Receive shifter, bit counter, command decode and address auto-increment.
    always_ff @(posedge clk_52 or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            rx_r        <= 8'h00;
            addr_r      <= 3'd0;
            rd_r        <= 1'b0;
        end else if (!active_s) begin
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
        end else if (sclk_rise_s) begin
            rx_r        <= rx_byte_s;
            bit_cnt_r   <= bit_cnt_r + 3'd1;
            byte_done_r <= (bit_cnt_r == 3'd7);
            if (bit_cnt_r == 3'd7) begin
                if (state_r == CMD) begin
                    rd_r   <= rx_byte_s[CMD_RW_BIT];
                    addr_r <= rx_byte_s[CMD_ADDR_MSB:0];
                end else begin
                    addr_r <= addr_r + 3'd1;
                end
            end
        end else if (sclk_fall_s) begin
            byte_done_r <= 1'b0;
        end
    end

    // Transmit shifter: reload on the first fall after a byte boundary, else shift.
    always_ff @(posedge clk_52 or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_r   <= 8'h00;
            miso_r <= 1'b0;
        end else begin
            if (!active_s) begin
                tx_r <= 8'h00;
            end else if (sclk_fall_s && (state_r == DATA) && rd_r) begin
                tx_r <= byte_done_r ? rd_data_s : {tx_r[6:0], 1'b0};
            end
            miso_r <= (active_s && (state_r == DATA) && rd_r) ? tx_r[7] : 1'b0;
        end
    end

    // Register read mux.
    always_comb begin
        rd_data_s = 8'h00;
        case (addr_r)
            ADDR_ID:       rd_data_s = ID_VALUE;
            ADDR_CTRL:     rd_data_s = ctrl_r;
            ADDR_INT_EN:   rd_data_s = {4'h0, int_en_r};
            ADDR_INT_STAT: rd_data_s = {4'h0, int_stat_r};
            default:       rd_data_s = scratch_r[addr_r[1:0]];
        endcase
    end

    // Interrupt next-state; a source edge outranks a same-cycle W1C.
    always_comb begin
        int_en_nxt_s   = int_en_r;
        int_stat_nxt_s = int_stat_r | irq_rise_s;
        if (wr_en_s && (addr_r == ADDR_INT_EN)) begin
            int_en_nxt_s = rx_byte_s[3:0];
        end else begin
            int_en_nxt_s = int_en_r;
        end
        if (wr_en_s && (addr_r == ADDR_INT_STAT)) begin
            int_stat_nxt_s = (int_stat_r & ~rx_byte_s[3:0]) | irq_rise_s;
        end else begin
            int_stat_nxt_s = int_stat_r | irq_rise_s;
        end
    end

    // Register file and registered interrupt output.
    always_ff @(posedge clk_52 or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_r     <= 8'h00;
            int_en_r   <= 4'h0;
            int_stat_r <= 4'h0;
            int_r      <= 1'b0;
            for (int i = 0; i < 4; i++) scratch_r[i] <= 8'h00;
        end else begin
            int_en_r   <= int_en_nxt_s;
            int_stat_r <= int_stat_nxt_s;
            int_r      <= |(int_stat_nxt_s & int_en_nxt_s);
            if (wr_en_s) begin
                case (addr_r)
                    ADDR_CTRL:     ctrl_r <= rx_byte_s;
                    ADDR_SCRATCH0,
                    ADDR_SCRATCH1,
                    ADDR_SCRATCH2,
                    ADDR_SCRATCH3: scratch_r[addr_r[1:0]] <= rx_byte_s;
                    default:       ;
                endcase
            end
        end
    end

    assign spi.MISO = miso_r;
    assign spi.INT  = int_r;
    assign ctrl     = ctrl_r;
endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios plus randomized
// transactions checked against a register-level model of the device.
module tb_spi_target;
    localparam int HALF = 6;

    logic       clk_52 = 1'b0;
    logic       RESET_N;
    logic [3:0] irq_src;
    logic [7:0] ctrl;

    spi_target_if spi_bus ();

    spi_target #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk_52(clk_52), .RESET_N(RESET_N), .spi(spi_bus),
        .irq_src(irq_src), .ctrl(ctrl)
    );

    always #10 clk_52 = ~clk_52;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] m_ctrl;
    logic [7:0] m_scratch [4];
    logic [3:0] m_int_en;
    logic [3:0] m_int_stat;
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 8'hA5;
            3'd1:    return m_ctrl;
            3'd2:    return {4'h0, m_int_en};
            3'd3:    return {4'h0, m_int_stat};
            default: return m_scratch[a[1:0]];
        endcase
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [7:0] d);
        case (a)
            3'd0:    ;
            3'd1:    m_ctrl = d;
            3'd2:    m_int_en = d[3:0];
            3'd3:    m_int_stat = m_int_stat & ~d[3:0];
            default: m_scratch[a[1:0]] = d;
        endcase
    endtask

    function automatic logic m_int();
        return |(m_int_stat & m_int_en);
    endfunction

    task automatic m_reset();
        m_ctrl = 8'h00; m_int_en = 4'h0; m_int_stat = 4'h0;
        for (int i = 0; i < 4; i++) m_scratch[i] = 8'h00;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_52);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_bus.MOSI = tx[7-i];
            wait_cyc(HALF);
            rx[7-i] = spi_bus.MISO;
            spi_bus.SCLK = 1'b1;
            wait_cyc(HALF);
            spi_bus.SCLK = 1'b0;
        end
    endtask

    task automatic xfer();
        logic [7:0] r;
        rx_q.delete();
        spi_bus.SS = 1'b0;
        wait_cyc(HALF);
        foreach (tx_q[k]) begin
            spi_bits(tx_q[k], 8, r);
            rx_q.push_back(r);
        end
        wait_cyc(4);
        spi_bus.SS = 1'b1;
        wait_cyc(8);
    endtask

    task automatic pulse_irq(input logic [3:0] mask);
        irq_src = mask;
        wait_cyc(6);
        irq_src = 4'h0;
        wait_cyc(6);
        m_int_stat = m_int_stat | mask;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        spi_bus.SS = 1'b1; spi_bus.SCLK = 1'b0; spi_bus.MOSI = 1'b0;
        irq_src = 4'h0;
        wait_cyc(4);
        RESET_N = 1'b1;
        wait_cyc(4);
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (spi_bus.MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", spi_bus.MISO); else pass_cnt++;
        total_cnt++;
        if (spi_bus.INT !== 1'b0) $display("FAIL reset_int: got %b expected 0", spi_bus.INT); else pass_cnt++;
        total_cnt++;
        if (ctrl !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", ctrl); else pass_cnt++;
    endtask

    task automatic test_id_read();
        tx_q = '{8'h80, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[0] !== 8'h00) $display("FAIL cmd_miso_zero: got %h expected 00", rx_q[0]); else pass_cnt++;
        total_cnt++;
        if (rx_q[1] !== 8'hA5) $display("FAIL id_read: got %h expected a5", rx_q[1]); else pass_cnt++;
        total_cnt++;
        if (ctrl !== 8'h00 || spi_bus.INT !== 1'b0)
            $display("FAIL id_idle_outputs: got ctrl=%h int=%b expected 00/0", ctrl, spi_bus.INT);
        else pass_cnt++;
    endtask

    task automatic test_ctrl_write();
        logic [7:0] r;
        int lat;
        spi_bus.SS = 1'b0;
        wait_cyc(HALF);
        spi_bits(8'h01, 8, r);
        spi_bits(8'h3C, 7, r);
        spi_bus.MOSI = 1'b0;
        wait_cyc(HALF);
        spi_bus.SCLK = 1'b1;
        lat = 0;
        while (ctrl !== 8'h3C && lat < 10) begin
            wait_cyc(1);
            lat++;
        end
        total_cnt++;
        if (ctrl !== 8'h3C || lat > 4)
            $display("FAIL ctrl_write_latency: got ctrl=%h after %0d cycles expected 3c within 4", ctrl, lat);
        else pass_cnt++;
        wait_cyc(HALF - lat);
        spi_bus.SCLK = 1'b0;
        wait_cyc(4);
        spi_bus.SS = 1'b1;
        wait_cyc(8);
        tx_q = '{8'h81, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'h3C) $display("FAIL ctrl_readback: got %h expected 3c", rx_q[1]); else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [7:0] exp_b [4];
        tx_q = '{8'h06, 8'h11, 8'h22, 8'h33};
        xfer();
        total_cnt++;
        if ((rx_q[1] | rx_q[2] | rx_q[3]) !== 8'h00)
            $display("FAIL write_miso_zero: got %h %h %h expected 00", rx_q[1], rx_q[2], rx_q[3]);
        else pass_cnt++;
        exp_b = '{8'h00, 8'h00, 8'h11, 8'h22};
        tx_q = '{8'h84, 8'h00, 8'h00, 8'h00, 8'h00};
        xfer();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rx_q[i+1] !== exp_b[i])
                $display("FAIL burst_read[%0d]: got %h expected %h", i, rx_q[i+1], exp_b[i]);
            else pass_cnt++;
        end
        tx_q = '{8'h80, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'hA5) $display("FAIL id_after_wrap: got %h expected a5", rx_q[1]); else pass_cnt++;
    endtask

    task automatic test_irq();
        int lat;
        tx_q = '{8'h02, 8'h05};
        xfer();
        irq_src = 4'h3;
        wait_cyc(6);
        irq_src = 4'h0;
        wait_cyc(6);
        total_cnt++;
        if (spi_bus.INT !== 1'b1) $display("FAIL irq_int_set: got %b expected 1", spi_bus.INT); else pass_cnt++;
        tx_q = '{8'h83, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'h03) $display("FAIL irq_stat: got %h expected 03", rx_q[1]); else pass_cnt++;
        tx_q = '{8'h03, 8'h01};
        xfer();
        total_cnt++;
        if (spi_bus.INT !== 1'b0) $display("FAIL irq_w1c_int: got %b expected 0", spi_bus.INT); else pass_cnt++;
        tx_q = '{8'h83, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'h02) $display("FAIL irq_w1c_stat: got %h expected 02", rx_q[1]); else pass_cnt++;
        irq_src = 4'h4;
        lat = 0;
        while (spi_bus.INT !== 1'b1 && lat < 10) begin
            wait_cyc(1);
            lat++;
        end
        total_cnt++;
        if (spi_bus.INT !== 1'b1 || lat > 4)
            $display("FAIL irq_latency: got int=%b after %0d cycles expected 1 within 4", spi_bus.INT, lat);
        else pass_cnt++;
        irq_src = 4'h0;
        wait_cyc(6);
        tx_q = '{8'h03, 8'h0F};
        xfer();
        total_cnt++;
        if (spi_bus.INT !== 1'b0) $display("FAIL irq_clear_all: got %b expected 0", spi_bus.INT); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] r;
        spi_bus.SS = 1'b0;
        wait_cyc(HALF);
        spi_bits(8'h01, 8, r);
        spi_bits(8'hFF, 5, r);
        wait_cyc(4);
        spi_bus.SS = 1'b1;
        wait_cyc(8);
        total_cnt++;
        if (ctrl !== 8'h3C) $display("FAIL abort_ctrl: got %h expected 3c", ctrl); else pass_cnt++;
        tx_q = '{8'h81, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'h3C) $display("FAIL abort_next_txn: got %h expected 3c", rx_q[1]); else pass_cnt++;
    endtask

    task automatic test_random();
        logic       rw;
        logic [2:0] a;
        logic [2:0] ak;
        int         len;
        logic [7:0] exp_q [$];
        do_reset();
        for (int it = 0; it < 40; it++) begin
            rw  = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 4);
            tx_q.delete();
            exp_q.delete();
            tx_q.push_back({rw, 4'($urandom_range(0, 15)), a});
            for (int k = 0; k < len; k++) begin
                ak = a + 3'(k);
                if (rw) begin
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    exp_q.push_back(m_read(ak));
                end else begin
                    tx_q.push_back(8'($urandom_range(0, 255)));
                    m_write(ak, tx_q[k+1]);
                    exp_q.push_back(8'h00);
                end
            end
            xfer();
            for (int k = 0; k < len; k++) begin
                total_cnt++;
                if (rx_q[k+1] !== exp_q[k])
                    $display("FAIL rand_miso[%0d.%0d]: got %h expected %h", it, k, rx_q[k+1], exp_q[k]);
                else pass_cnt++;
            end
            total_cnt++;
            if (ctrl !== m_ctrl) $display("FAIL rand_ctrl[%0d]: got %h expected %h", it, ctrl, m_ctrl); else pass_cnt++;
            if ((it % 4) == 3) pulse_irq(4'($urandom_range(0, 15)));
            total_cnt++;
            if (spi_bus.INT !== m_int()) $display("FAIL rand_int[%0d]: got %b expected %b", it, spi_bus.INT, m_int()); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        tx_q = '{8'h01, 8'h5A};
        xfer();
        tx_q = '{8'h02, 8'h01};
        xfer();
        m_write(3'd1, 8'h5A);
        m_write(3'd2, 8'h01);
        pulse_irq(4'h1);
        total_cnt++;
        if (spi_bus.INT !== 1'b1) $display("FAIL prereset_int: got %b expected 1", spi_bus.INT); else pass_cnt++;
        spi_bus.SS = 1'b0;
        wait_cyc(HALF);
        spi_bits(8'h81, 8, r);
        spi_bits(8'h00, 3, r);
        wait_cyc(HALF);
        total_cnt++;
        if (spi_bus.MISO !== m_ctrl[4]) $display("FAIL midread_miso: got %b expected %b", spi_bus.MISO, m_ctrl[4]); else pass_cnt++;
        RESET_N = 1'b0;
        #1;
        total_cnt++;
        if (spi_bus.MISO !== 1'b0 || spi_bus.INT !== 1'b0 || ctrl !== 8'h00)
            $display("FAIL async_reset: got miso=%b int=%b ctrl=%h expected 0/0/00", spi_bus.MISO, spi_bus.INT, ctrl);
        else pass_cnt++;
        wait_cyc(2);
        spi_bus.SS = 1'b1;
        wait_cyc(4);
        RESET_N = 1'b1;
        m_reset();
        wait_cyc(4);
        tx_q = '{8'h81, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== m_read(3'd1)) $display("FAIL postreset_ctrl: got %h expected %h", rx_q[1], m_read(3'd1)); else pass_cnt++;
        tx_q = '{8'h80, 8'h00};
        xfer();
        total_cnt++;
        if (rx_q[1] !== 8'hA5) $display("FAIL postreset_id: got %h expected a5", rx_q[1]); else pass_cnt++;
    endtask

    initial begin
        RESET_N = 1'b0;
        spi_bus.SS = 1'b1; spi_bus.SCLK = 1'b0; spi_bus.MOSI = 1'b0;
        irq_src = 4'h0;
        @(negedge clk_52);
        test_reset();
        test_id_read();
        test_ctrl_write();
        test_burst();
        test_irq();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
